// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one 24x24 mantissa multiplier, with watchdog abort
module mul_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            Req_valid,
  input  logic [24*NUM_REQ-1:0]         Req_datain1,
  input  logic [24*NUM_REQ-1:0]         Req_datain2,
  output logic [NUM_REQ-1:0]            Req_ack,
  output logic [47:0]                   Req_dataout,
  output logic [2:0]                    Req_exc,
  output logic                          Busy,
  output logic [$clog2(NUM_REQ)-1:0]    Grant_id,
  output logic [23:0]                   Multi_datain1,
  output logic [23:0]                   Multi_datain2,
  output logic                          Multi_valid,
  input  logic [47:0]                   Multi_dataout,
  input  logic [2:0]                    Multi_Exc,
  input  logic                          Multi_ack
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
  state_t state;
  logic [GW-1:0] ptr, win, j;
  logic [WW-1:0] wd;
  always_comb begin
    win = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = GW'((int'(ptr) + i) % NUM_REQ);
      if (Req_valid[j]) win = j;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr <= '0;
      wd <= '0;
      Req_ack <= '0;
      Req_dataout <= '0;
      Req_exc <= '0;
      Busy <= 1'b0;
      Grant_id <= '0;
      Multi_valid <= 1'b0;
      Multi_datain1 <= '0;
      Multi_datain2 <= '0;
    end else begin
      case (state)
        IDLE: if (|Req_valid) begin
          state <= ISSUE;
          Busy <= 1'b1;
          Grant_id <= win;
          ptr <= (win == GW'(NUM_REQ - 1)) ? '0 : win + GW'(1);
          Multi_datain1 <= Req_datain1[24*win +: 24];
          Multi_datain2 <= Req_datain2[24*win +: 24];
          Multi_valid <= 1'b1;
        end
        ISSUE: begin
          wd <= wd + WW'(1);
          if (Multi_ack || wd == WW'(TIMEOUT - 1)) begin
            state <= RESPOND;
            Multi_valid <= 1'b0;
            Req_ack <= NUM_REQ'(1) << Grant_id;
            Req_dataout <= Multi_ack ? Multi_dataout : '0;
            Req_exc <= Multi_ack ? Multi_Exc : 3'b111;
          end
        end
        RESPOND: begin
          state <= IDLE;
          Busy <= 1'b0;
          wd <= '0;
          Req_ack <= '0;
          Req_dataout <= '0;
          Req_exc <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
